int_gateway: RTL and testbench
==============================

# int_gateway

Peripheral-side interrupt gateway: it converts raw GPIO/UART/IIC/SPI events into held interrupt request levels, and keeps each level asserted until the core claims it. It then blocks that source until the core signals completion. Its `int_req` outputs drive the `gpio_int`/`uart_int`/`iic_int`/`spi_int` inputs of the core interrupt bus. It also provides a small register port for enable, trigger mode, pending and in-service status.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of sources. Bit 0 is GPIO (code 1), bit 1 UART (2), bit 2 IIC (3), bit 3 SPI (4).
- `CODE_W`, default 8: width of interrupt codes.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `src_evt`  in  NUM_SRC  raw peripheral event lines, synchronous to `clk`.
- `int_req`  out  NUM_SRC  held request per source, to the interrupt bus.
- `top_code`  out  CODE_W  code of the highest-priority active request (lowest index wins), 0 if none.
- `claim_en`  in  1  one-cycle claim strobe from the core.
- `claim_code`  in  CODE_W  code being claimed.
- `complete_en`  in  1  one-cycle completion strobe.
- `complete_code`  in  CODE_W  code being completed.
- `reg_wr_en`  in  1  register write strobe.
- `reg_addr`  in  3  register select.
- `reg_wdata`  in  32  write data; bits [NUM_SRC-1:0] are used.
- `reg_rdata`  out  32  combinational read data; unused bits read 0.

## Operation
- Each source has a state machine with three states: IDLE, PENDING and IN_SERVICE. It also has a 1-deep `repend` flag.
- **Trigger modes**
  - Level mode (`mode`=0): IDLE goes to PENDING on any cycle where `src_evt` is high.
  - Edge mode (`mode`=1): IDLE goes to PENDING on a 0→1 transition of `src_evt`, measured against a registered previous sample.
- **Request output:** `int_req[i]` = PENDING & `enable[i]`. A disabled source still latches PENDING, but its request is masked.
- **Claim:** `claim_en` with code i+1 moves source i from PENDING to IN_SERVICE. A claim for a source that is not PENDING, or for code 0 or a code above NUM_SRC, is ignored.
- **Complete:** `complete_en` with code i+1 moves source i from IN_SERVICE to IDLE.
  - If `repend` is set, the source goes to PENDING instead and `repend` is cleared.
  - A completion for a source that is not IN_SERVICE is ignored.
- **Repend:** an edge-mode rising edge that arrives while the source is PENDING or IN_SERVICE sets `repend`. Further edges are merged into it.
- **Register map:**
  - 0: `enable`, RW, reset 0.
  - 1: `mode`, RW, reset 0.
  - 2: `pending`, read; write-1-to-clear moves PENDING to IDLE.
  - 3: `in_service`, RO.
  - 4: `repend`, RO.
  - 5–7: read 0; writes ignored.

## Timing
- Reset values:
  - all states IDLE; `repend`, `enable`, `mode` and the previous-sample register are 0;
  - `int_req`=0, `top_code`=0, and `reg_rdata` reads 0 for any address.
- Latency:
  - A qualifying event sampled at edge N makes PENDING visible after edge N. `int_req` and `top_code` follow combinationally from state, so both are valid in the cycle after the event.
  - A claim at edge N drops `int_req` after edge N.
  - A complete at edge N makes the source IDLE, or PENDING if `repend` is set, after edge N.
- Level mode after complete: if `src_evt` is still high, the source re-enters PENDING at the next edge (IDLE for one cycle).
- Simultaneous events at the same edge:
  - Claim and a new edge on the same source: the claim wins, and `repend` is set.
  - Complete and a new edge: the source goes to PENDING and `repend` ends at 0.
  - Pending W1C and a new event: the clear wins for the PENDING state. In edge mode the edge sets `repend`; in level mode the source re-pends on the next cycle.
  - Claim and complete with different codes: both are applied independently.
- A register write takes effect after its edge. A disable drops `int_req` with no effect on state.
- A reset asserted mid-operation clears everything immediately and asynchronously, including an IN_SERVICE source. No request survives reset.

## Structure
- Package `int_gw_pkg` holds:
  - the state encoding (IDLE=0, PENDING=1, IN_SERVICE=2);
  - the register address constants (`GW_ENABLE`..`GW_REPEND`);
  - a code-to-index helper function.
- Sub-module `int_gw_src`, one instance per source, generated. It contains the state machine, the edge detector and `repend`. Inputs: `evt`, `mode`, `claim_hit`, `complete_hit`, `clr_hit`. Outputs: `state`, `repend`.
- The top level holds `enable`/`mode`, claim/complete code decode, the priority encoder for `top_code`, and the read mux.

## Test plan
- Level event:
  - Stimulus: enable=4'hF, `src_evt[1]` pulsed high 1 cycle.
  - Required: `int_req`=4'b0010 and `top_code`=2 the next cycle; claim code 2 → `int_req`=0, `in_service`=4'b0010; complete code 2 → all IDLE.
- Edge mode with repend:
  - Stimulus: mode=4'hF, edge on src 0, claim 1, two more edges during service, then complete 1.
  - Required: `repend[0]` sets to 1 after the first in-service edge; after complete, PENDING with `repend`=0, and only one further request.
- Priority and mask:
  - Stimulus: sources 2 and 3 pending, enable=4'b1000.
  - Required: `int_req`=4'b1000 and `top_code`=4; after enable=4'hF, `top_code`=3.
- Illegal handshakes:
  - Stimulus: claim code 0, claim code 5, complete code 1 while src 0 is PENDING.
  - Required: no state change anywhere.
- Simultaneous events:
  - Stimulus: in edge mode, claim code 1 on the same edge as a new rising edge on src 0.
  - Required: IN_SERVICE with `repend`=1. A W1C on addr 2 concurrent with a level event → IDLE for one cycle, then PENDING.
- Reset mid-service:
  - Stimulus: src 3 IN_SERVICE and src 1 PENDING; assert `rst` between clock edges.
  - Required: `int_req`=0, `top_code`=0 and reads of addr 2, 3 and 4 return 0 immediately; after reset release, reads of addr 0 and 1 return 0.

Source files
------------

// File: rtl/int_gw_pkg.sv
// Shared types and constants for the interrupt gateway.
package int_gw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PENDING    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } gw_state_e;

    localparam logic [2:0] GW_ENABLE     = 3'd0;
    localparam logic [2:0] GW_MODE       = 3'd1;
    localparam logic [2:0] GW_PENDING    = 3'd2;
    localparam logic [2:0] GW_IN_SERVICE = 3'd3;
    localparam logic [2:0] GW_REPEND     = 3'd4;

    // Code 0 wraps to all-ones, so it can never match a real source index.
    function automatic logic [31:0] code_to_idx(input logic [31:0] code);
        return code - 32'd1;
    endfunction

endpackage

// File: rtl/int_gw_src.sv
// Per-source request state machine with edge detector and one-deep repend flag.
//
//   state         | meaning
//   --------------+----------------------------------------------------
//   ST_IDLE       | no request; waiting for a qualifying event
//   ST_PENDING    | request held toward the core until claimed or cleared
//   ST_IN_SERVICE | claimed; source blocked until the core completes it
module int_gw_src
    import int_gw_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      evt,
    input  logic      mode,
    input  logic      claim_hit,
    input  logic      complete_hit,
    input  logic      clr_hit,
    output gw_state_e state,
    output logic      repend
);

    gw_state_e r_state;
    logic      r_repend;
    logic      r_evt_prev;
    logic      w_rise;
    logic      w_trig;
    logic      w_edge_evt;

    assign w_rise     = evt & ~r_evt_prev;
    assign w_trig     = mode ? w_rise : evt;
    assign w_edge_evt = mode & w_rise;

    // Request FSM; edges seen while busy are folded into repend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_repend   <= 1'b0;
            r_evt_prev <= 1'b0;
        end else begin
            r_evt_prev <= evt;
            case (r_state)
                ST_IDLE: begin
                    if (w_trig)
                        r_state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (claim_hit)
                        r_state <= ST_IN_SERVICE;
                    else if (clr_hit)
                        r_state <= ST_IDLE;
                    if (w_edge_evt)
                        r_repend <= 1'b1;
                end
                ST_IN_SERVICE: begin
                    if (complete_hit) begin
                        r_state  <= (r_repend || w_edge_evt) ? ST_PENDING : ST_IDLE;
                        r_repend <= 1'b0;
                    end else if (w_edge_evt) begin
                        r_repend <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state  = r_state;
    assign repend = r_repend;

endmodule

// File: rtl/int_gateway.sv
// Interrupt gateway top: config registers, handshake decode, priority and readback.
module int_gateway
    import int_gw_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CODE_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  src_evt,
    output logic [NUM_SRC-1:0]  int_req,
    output logic [CODE_W-1:0]   top_code,
    input  logic                claim_en,
    input  logic [CODE_W-1:0]   claim_code,
    input  logic                complete_en,
    input  logic [CODE_W-1:0]   complete_code,
    input  logic                reg_wr_en,
    input  logic [2:0]          reg_addr,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata
);

    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] w_claim_hit;
    logic [NUM_SRC-1:0] w_complete_hit;
    logic [NUM_SRC-1:0] w_clr_hit;
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_in_service;
    logic [NUM_SRC-1:0] w_repend;
    logic [NUM_SRC-1:0] w_req;
    logic [31:0]        w_claim_idx;
    logic [31:0]        w_complete_idx;
    logic               w_unused_wdata;

    assign w_claim_idx    = code_to_idx(32'(claim_code));
    assign w_complete_idx = code_to_idx(32'(complete_code));
    assign w_unused_wdata = ^reg_wdata;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        gw_state_e w_state;

        assign w_claim_hit[i]    = claim_en    && (w_claim_idx    == 32'(i));
        assign w_complete_hit[i] = complete_en && (w_complete_idx == 32'(i));
        assign w_clr_hit[i]      = reg_wr_en && (reg_addr == GW_PENDING) && reg_wdata[i];

        int_gw_src u_src (
            .clk          (clk),
            .rst          (rst),
            .evt          (src_evt[i]),
            .mode         (r_mode[i]),
            .claim_hit    (w_claim_hit[i]),
            .complete_hit (w_complete_hit[i]),
            .clr_hit      (w_clr_hit[i]),
            .state        (w_state),
            .repend       (w_repend[i])
        );

        assign w_pending[i]    = (w_state == ST_PENDING);
        assign w_in_service[i] = (w_state == ST_IN_SERVICE);
    end

    // Enable and trigger-mode configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable <= '0;
            r_mode   <= '0;
        end else if (reg_wr_en) begin
            if (reg_addr == GW_ENABLE)
                r_enable <= reg_wdata[NUM_SRC-1:0];
            if (reg_addr == GW_MODE)
                r_mode <= reg_wdata[NUM_SRC-1:0];
        end
    end

    assign w_req   = w_pending & r_enable;
    assign int_req = w_req;

    // Lowest index wins: scan high to low so the last hit is the winner.
    always_comb begin
        top_code = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i])
                top_code = CODE_W'(i + 1);
        end
    end

    // Register readback; unmapped addresses read zero.
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            GW_ENABLE:     reg_rdata = 32'(r_enable);
            GW_MODE:       reg_rdata = 32'(r_mode);
            GW_PENDING:    reg_rdata = 32'(w_pending);
            GW_IN_SERVICE: reg_rdata = 32'(w_in_service);
            GW_REPEND:     reg_rdata = 32'(w_repend);
            default:       reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_gateway.sv
// Self-checking bench for int_gateway: vector table, directed corner sequences, random vs. model.
module tb_int_gateway;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_evt;
    logic [3:0]  int_req;
    logic [7:0]  top_code;
    logic        claim_en;
    logic [7:0]  claim_code;
    logic        complete_en;
    logic [7:0]  complete_code;
    logic        reg_wr_en;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    int n_pass  = 0;
    int n_total = 0;

    int_gateway #(.NUM_SRC(4), .CODE_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_evt       (src_evt),
        .int_req       (int_req),
        .top_code      (top_code),
        .claim_en      (claim_en),
        .claim_code    (claim_code),
        .complete_en   (complete_en),
        .complete_code (complete_code),
        .reg_wr_en     (reg_wr_en),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  evt;
        logic        clm;
        logic [7:0]  clm_code;
        logic        cmp;
        logic [7:0]  cmp_code;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  req;
        logic [7:0]  top;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int evt, int clm, int clm_code, int cmp, int cmp_code,
                                int wr, int addr, int wdata, int req, int top, int rd);
        vec_t v;
        v.evt = 4'(evt);  v.clm = 1'(clm);  v.clm_code = 8'(clm_code);
        v.cmp = 1'(cmp);  v.cmp_code = 8'(cmp_code);
        v.wr = 1'(wr);    v.addr = 3'(addr); v.wdata = 32'(wdata);
        v.req = 4'(req);  v.top = 8'(top);   v.rd = 32'(rd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        claim_en = 1'b0;  claim_code = '0;
        complete_en = 1'b0; complete_code = '0;
        reg_wr_en = 1'b0; reg_wdata = '0;
    endtask

    // Behavioural reference: per-source status labels and sticky flags.
    localparam int M_IDLE = 0, M_PEND = 1, M_SVC = 2;
    int       m_st[4];
    bit       m_rep[4];
    bit       m_prev[4];
    bit [3:0] m_en;
    bit [3:0] m_mode;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = M_IDLE; m_rep[i] = 0; m_prev[i] = 0;
        end
        m_en = 0; m_mode = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            bit rise, edge_evt, fire, clm, cmp, clr;
            rise     = src_evt[i] && !m_prev[i];
            edge_evt = m_mode[i] && rise;
            fire     = m_mode[i] ? rise : src_evt[i];
            clm = claim_en && (int'(claim_code) == i + 1);
            cmp = complete_en && (int'(complete_code) == i + 1);
            clr = reg_wr_en && (reg_addr == 3'd2) && reg_wdata[i];
            if (m_st[i] == M_IDLE) begin
                if (fire) m_st[i] = M_PEND;
            end else if (m_st[i] == M_PEND) begin
                if (edge_evt) m_rep[i] = 1;
                if (clm) m_st[i] = M_SVC;
                else if (clr) m_st[i] = M_IDLE;
            end else begin
                if (cmp) begin
                    m_st[i] = (m_rep[i] || edge_evt) ? M_PEND : M_IDLE;
                    m_rep[i] = 0;
                end else if (edge_evt) begin
                    m_rep[i] = 1;
                end
            end
            m_prev[i] = src_evt[i];
        end
        if (reg_wr_en && reg_addr == 3'd0) m_en = reg_wdata[3:0];
        if (reg_wr_en && reg_addr == 3'd1) m_mode = reg_wdata[3:0];
    endtask

    function automatic logic [3:0] m_req();
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = (m_st[i] == M_PEND) && m_en[i];
        return r;
    endfunction

    function automatic logic [7:0] m_top();
        logic [3:0] r = m_req();
        for (int i = 0; i < 4; i++) if (r[i]) return 8'(i + 1);
        return 8'd0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        logic [3:0] v = '0;
        case (a)
            3'd0: v = m_en;
            3'd1: v = m_mode;
            3'd2: for (int i = 0; i < 4; i++) v[i] = (m_st[i] == M_PEND);
            3'd3: for (int i = 0; i < 4; i++) v[i] = (m_st[i] == M_SVC);
            3'd4: for (int i = 0; i < 4; i++) v[i] = m_rep[i];
            default: v = '0;
        endcase
        return 32'(v);
    endfunction

    initial begin
        // Table: evt, clm, clm_code, cmp, cmp_code, wr, addr, wdata, exp req, exp top, exp rdata
        vecs.push_back(mk(0,  0,0, 0,0, 1,0,'hF,  0,   0, 'hF));
        vecs.push_back(mk(2,  0,0, 0,0, 0,2,0,    2,   2, 2));
        vecs.push_back(mk(0,  1,2, 0,0, 0,3,0,    0,   0, 2));
        vecs.push_back(mk(0,  0,0, 1,2, 0,3,0,    0,   0, 0));
        vecs.push_back(mk(0,  0,0, 0,0, 0,2,0,    0,   0, 0));
        vecs.push_back(mk(0,  0,0, 0,0, 1,0,8,    0,   0, 8));
        vecs.push_back(mk('hC,0,0, 0,0, 0,2,0,    8,   4, 'hC));
        vecs.push_back(mk(0,  0,0, 0,0, 1,0,'hF,  'hC, 3, 'hF));
        vecs.push_back(mk(1,  0,0, 0,0, 0,2,0,    'hD, 1, 'hD));
        vecs.push_back(mk(0,  1,0, 0,0, 0,2,0,    'hD, 1, 'hD));
        vecs.push_back(mk(0,  1,5, 0,0, 0,2,0,    'hD, 1, 'hD));
        vecs.push_back(mk(0,  0,0, 1,1, 0,3,0,    'hD, 1, 0));
        vecs.push_back(mk(0,  0,0, 0,0, 1,2,'hD,  0,   0, 0));
        vecs.push_back(mk(1,  0,0, 0,0, 0,2,0,    1,   1, 1));
        vecs.push_back(mk(1,  0,0, 0,0, 1,2,1,    0,   0, 0));
        vecs.push_back(mk(1,  0,0, 0,0, 0,2,0,    1,   1, 1));
        vecs.push_back(mk(0,  0,0, 0,0, 1,5,'hF,  1,   1, 0));
        vecs.push_back(mk(0,  0,0, 0,0, 1,2,'hF,  0,   0, 0));
        vecs.push_back(mk(0,  0,0, 0,0, 1,0,0,    0,   0, 0));
        vecs.push_back(mk(4,  0,0, 0,0, 0,2,0,    0,   0, 4));
        vecs.push_back(mk(0,  0,0, 0,0, 1,0,'hF,  4,   3, 'hF));
        vecs.push_back(mk(0,  0,0, 0,0, 1,2,'hF,  0,   0, 0));

        rst = 1'b1; src_evt = '0; reg_addr = '0; idle_in();
        #2;
        chk("rst_req", 32'(int_req), 0);
        chk("rst_top", 32'(top_code), 0);
        for (int a = 0; a < 8; a++) begin
            reg_addr = 3'(a); #1;
            chk($sformatf("rst_rd%0d", a), reg_rdata, 0);
        end
        tick(); rst = 1'b0; tick();

        foreach (vecs[k]) begin
            src_evt = vecs[k].evt;
            claim_en = vecs[k].clm; claim_code = vecs[k].clm_code;
            complete_en = vecs[k].cmp; complete_code = vecs[k].cmp_code;
            reg_wr_en = vecs[k].wr; reg_addr = vecs[k].addr; reg_wdata = vecs[k].wdata;
            tick();
            chk($sformatf("vec%0d_req", k), 32'(int_req), 32'(vecs[k].req));
            chk($sformatf("vec%0d_top", k), 32'(top_code), 32'(vecs[k].top));
            chk($sformatf("vec%0d_rd", k), reg_rdata, vecs[k].rd);
        end
        idle_in(); src_evt = '0;

        // Edge mode with repend merging.
        reg_wr_en = 1; reg_addr = 3'd1; reg_wdata = 32'hF; tick(); reg_wr_en = 0;
        src_evt = 4'b0001; reg_addr = 3'd2; tick();
        chk("edge_pend", reg_rdata, 1); chk("edge_req", 32'(int_req), 1);
        src_evt = 0; claim_en = 1; claim_code = 8'd1; reg_addr = 3'd3; tick(); claim_en = 0;
        chk("edge_svc", reg_rdata, 1); chk("edge_claim_req", 32'(int_req), 0);
        src_evt = 4'b0001; reg_addr = 3'd4; tick();
        chk("repend_set", reg_rdata, 1);
        src_evt = 0; tick(); src_evt = 4'b0001; tick(); src_evt = 0;
        chk("repend_merged", reg_rdata, 1);
        complete_en = 1; complete_code = 8'd1; reg_addr = 3'd2; tick(); complete_en = 0;
        chk("repend_repost", reg_rdata, 1); chk("repend_req", 32'(int_req), 1);
        reg_addr = 3'd4; #1; chk("repend_cleared", reg_rdata, 0);
        claim_en = 1; claim_code = 8'd1; tick(); claim_en = 0;
        complete_en = 1; complete_code = 8'd1; tick(); complete_en = 0;
        reg_addr = 3'd2; #1;
        chk("single_repost_pend", reg_rdata, 0); chk("single_repost_req", 32'(int_req), 0);

        // Claim coinciding with a fresh edge.
        src_evt = 4'b0001; tick(); src_evt = 0; tick();
        src_evt = 4'b0001; claim_en = 1; claim_code = 8'd1; tick(); claim_en = 0;
        reg_addr = 3'd3; #1; chk("clm_edge_svc", reg_rdata, 1);
        reg_addr = 3'd4; #1; chk("clm_edge_rep", reg_rdata, 1);
        // Complete coinciding with a fresh edge.
        src_evt = 0; tick();
        src_evt = 4'b0001; complete_en = 1; complete_code = 8'd1; tick(); complete_en = 0;
        reg_addr = 3'd2; #1; chk("cmp_edge_pend", reg_rdata, 1);
        reg_addr = 3'd4; #1; chk("cmp_edge_rep", reg_rdata, 0);
        // Claim and complete of different sources on the same edge.
        src_evt = 4'b0011; tick();
        claim_en = 1; claim_code = 8'd1; tick();
        claim_code = 8'd2; complete_en = 1; complete_code = 8'd1; tick();
        claim_en = 0; complete_en = 0;
        reg_addr = 3'd3; #1; chk("dual_svc", reg_rdata, 2);
        reg_addr = 3'd2; #1; chk("dual_pend", reg_rdata, 0);
        complete_en = 1; complete_code = 8'd2; tick(); complete_en = 0; src_evt = 0;

        // Reset mid-service.
        reg_wr_en = 1; reg_addr = 3'd1; reg_wdata = 0; tick(); reg_wr_en = 0;
        src_evt = 4'b1010; tick();
        src_evt = 0; claim_en = 1; claim_code = 8'd4; tick(); claim_en = 0;
        chk("pre_rst_req", 32'(int_req), 2);
        #2; rst = 1'b1; #1;
        chk("mid_rst_req", 32'(int_req), 0);
        chk("mid_rst_top", 32'(top_code), 0);
        for (int a = 2; a <= 4; a++) begin
            reg_addr = 3'(a); #1;
            chk($sformatf("mid_rst_rd%0d", a), reg_rdata, 0);
        end
        rst = 1'b0; tick();
        reg_addr = 3'd0; #1; chk("post_rst_en", reg_rdata, 0);
        reg_addr = 3'd1; #1; chk("post_rst_mode", reg_rdata, 0);
        chk("post_rst_req", 32'(int_req), 0);

        // Randomized run against the reference model.
        rst = 1'b1; idle_in(); src_evt = 0; tick(); rst = 1'b0; model_reset(); tick();
        reg_wr_en = 1; reg_addr = 3'd0; reg_wdata = 32'hF; model_step(); tick();
        for (int c = 0; c < 1500; c++) begin
            src_evt     = 4'($urandom_range(0, 15));
            claim_en    = ($urandom_range(0, 3) == 0);
            claim_code  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : m_top();
            complete_en = ($urandom_range(0, 2) == 0);
            complete_code = 8'($urandom_range(0, 5));
            reg_wr_en   = ($urandom_range(0, 9) == 0);
            reg_addr    = 3'($urandom_range(0, 7));
            reg_wdata   = $urandom();
            if (reg_wr_en && reg_addr == 3'd0 && $urandom_range(0, 1) == 0) reg_wdata[3:0] = 4'hF;
            model_step();
            tick();
            chk($sformatf("rnd%0d_req", c), 32'(int_req), 32'(m_req()));
            chk($sformatf("rnd%0d_top", c), 32'(top_code), 32'(m_top()));
            chk($sformatf("rnd%0d_rd", c), reg_rdata, m_rd(reg_addr));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
